// File: rtl/fetch_sequencer.sv
// Fetch-stage control FSM: arbitrates halt, taken branches and pipeline stalls,
// drives fetch-unit redirect/stall controls and flush bubbles after redirects.
module fetch_sequencer #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned STALL_LIMIT  = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              branch_req,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              load_use_hazard,
    input  logic              mem_busy,
    input  logic              halt_req,
    input  logic              resume,
    output logic              pc_mux_sel,
    output logic [ADDR_W-1:0] jmp_loc,
    output logic              stall,
    output logic              stall_pm,
    output logic              flush,
    output logic              halted,
    output logic              stall_timeout
);

    typedef enum logic [2:0] {
        RUN,
        STALL,
        JUMP,
        FLUSH,
        HALT
    } state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] LIMIT        = 8'(STALL_LIMIT);

    state_t            state;
    state_t            nxt;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;
    logic [2:0]        flush_left;
    logic [7:0]        stall_cnt;
    logic [7:0]        stall_cnt_nxt;
    logic              take_live;
    logic              stall_cond;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;

    always_comb begin
        take_live       = branch_req & branch_taken;
        stall_cond      = load_use_hazard | mem_busy;
        redirect        = (take_live | pend_valid) & ~mem_busy;
        redirect_target = take_live ? branch_target : pend_target;
    end

    // HALT is only left through resume; redirects wait until the cycle after exit.
    always_comb begin
        nxt = state;
        if (state == HALT) begin
            nxt = (resume && !halt_req) ? RUN : HALT;
        end else if (halt_req) begin
            nxt = HALT;
        end else if (redirect) begin
            nxt = JUMP;
        end else begin
            unique case (state)
                RUN:     nxt = stall_cond ? STALL : RUN;
                STALL:   nxt = stall_cond ? STALL : RUN;
                JUMP: begin
                    if (FLUSH_CYCLES > 1)
                        nxt = FLUSH;
                    else
                        nxt = stall_cond ? STALL : RUN;
                end
                FLUSH: begin
                    if (stall_cond)
                        nxt = STALL;
                    else if (flush_left <= 3'd1)
                        nxt = RUN;
                    else
                        nxt = FLUSH;
                end
                default: nxt = RUN;
            endcase
        end
    end

    always_comb begin
        stall_cnt_nxt = 8'd1;
        if (state == STALL)
            stall_cnt_nxt = (stall_cnt >= LIMIT) ? LIMIT : stall_cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            pend_valid    <= 1'b0;
            pend_target   <= '0;
            flush_left    <= '0;
            stall_cnt     <= '0;
            pc_mux_sel    <= 1'b0;
            jmp_loc       <= '0;
            stall         <= 1'b0;
            stall_pm      <= 1'b0;
            flush         <= 1'b0;
            halted        <= 1'b0;
            stall_timeout <= 1'b0;
        end else begin
            state      <= nxt;
            pc_mux_sel <= (nxt == JUMP);
            flush      <= (nxt == JUMP) || (nxt == FLUSH);
            stall      <= (nxt == STALL) || (nxt == HALT);
            stall_pm   <= (nxt == STALL) || (nxt == HALT);
            halted     <= (nxt == HALT);

            // A taken branch not consumed by JUMP this cycle is parked; newest wins.
            if (nxt == JUMP) begin
                pend_valid <= 1'b0;
                jmp_loc    <= redirect_target;
                flush_left <= FLUSH_RELOAD;
            end else begin
                if (take_live) begin
                    pend_valid  <= 1'b1;
                    pend_target <= branch_target;
                end
                if (state == FLUSH && nxt == FLUSH)
                    flush_left <= flush_left - 3'd1;
            end

            if (nxt == STALL) begin
                stall_cnt <= stall_cnt_nxt;
                if (stall_cnt_nxt >= LIMIT)
                    stall_timeout <= 1'b1;
            end else begin
                stall_cnt <= '0;
            end
        end
    end

endmodule
